// File: rtl/ntt_carry_resolve.sv
// ntt_carry_resolve
//   Sits behind the inverse-NTT stage of the hybrid modular multiplier.
//   It takes K = N/W unreduced coefficients, least significant first, and
//   ripples carries between limbs to build sum(coef_i * 2^(W*i)). It then
//   reduces that integer modulo M by repeated conditional subtraction,
//   capped at MAX_SUB iterations, and hands the residue to the top-level FSM.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   start        begin a job; sampled only in IDLE
//   m_in [N]     modulus, latched on an accepted start
//   coef_valid   coefficient valid
//   coef_ready   coefficient ready, high only while accumulating
//   coef_data    unsigned coefficient, CW bits
//   res_valid    result valid, held until res_ready
//   res_ready    consumer ready
//   res_data [N] residue, or a partial value when err is set
//   err          modulus was zero or the subtraction budget ran out
//   busy         high whenever the block is not idle
//   cyc_cnt [16] only when CRES_CYCLE_CNT_EN is defined: saturating count of
//                busy cycles since the last accepted start, frozen while
//                res_valid is high
//
// Configuration macro: CRES_CYCLE_CNT_EN

module ntt_carry_resolve #(
  parameter int N       = 1024,
  parameter int W       = 32,
  parameter int CW      = 80,
  parameter int MAX_SUB = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  m_in,
  input  logic          coef_valid,
  output logic          coef_ready,
  input  logic [CW-1:0] coef_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_data,
  output logic          err,
  output logic          busy
`ifdef CRES_CYCLE_CNT_EN
  ,
  output logic [15:0]   cyc_cnt
`endif
);

  localparam int K     = N / W;
  localparam int EXT   = N + CW - W + 1;
  // The carry out of a limb is what is left of a CW+1 bit sum above W bits.
  localparam int CAR_W = CW - W + 1;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int SUB_W = (MAX_SUB < 1) ? 1 : $clog2(MAX_SUB + 1);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(K - 1);
  localparam logic [SUB_W-1:0] SUB_LIMIT = SUB_W'(MAX_SUB);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    FLUSH,
    REDUCE,
    OUT
  } state_t;

  state_t           state;
  logic [N-1:0]     m_r;
  logic [EXT-1:0]   ext;
  logic [CAR_W-1:0] carry;
  logic [CNT_W-1:0] cnt;
  logic [SUB_W-1:0] sub_cnt;

  logic [CW:0]      sum;
  logic [EXT-1:0]   m_ext;
  logic             ext_ge_m;
  logic             coef_hs;

  // Incoming coefficient plus the carry left over from the previous limb.
  assign sum      = {1'b0, coef_data} + {{W{1'b0}}, carry};
  assign m_ext    = {{CAR_W{1'b0}}, m_r};
  assign ext_ge_m = (ext >= m_ext);
  assign coef_hs  = coef_valid && coef_ready;

  // Main controller: accumulate limbs, fold the final carry into the top of
  // the extended accumulator, reduce, then hold the result for the consumer.
  // All outputs are registered and change together with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      m_r        <= '0;
      ext        <= '0;
      carry      <= '0;
      cnt        <= '0;
      sub_cnt    <= '0;
      coef_ready <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_r        <= m_in;
            ext        <= '0;
            carry      <= '0;
            cnt        <= '0;
            sub_cnt    <= '0;
            coef_ready <= 1'b1;
            busy       <= 1'b1;
            state      <= ACCUM;
          end
        end

        ACCUM: begin
          if (coef_hs) begin
            for (int i = 0; i < K; i++) begin
              if (cnt == CNT_W'(i)) begin
                ext[W*i +: W] <= sum[W-1:0];
              end
            end
            carry <= sum[CW:W];
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              coef_ready <= 1'b0;
              state      <= FLUSH;
            end
          end
        end

        FLUSH: begin
          // The last carry becomes the bits above N; EXT is sized so that
          // nothing is lost here.
          ext[EXT-1:N] <= carry;
          if (m_r == '0) begin
            // A zero modulus cannot be reduced; report the low limbs as-is.
            err       <= 1'b1;
            res_data  <= ext[N-1:0];
            res_valid <= 1'b1;
            state     <= OUT;
          end else begin
            state <= REDUCE;
          end
        end

        REDUCE: begin
          if (ext_ge_m) begin
            if (sub_cnt == SUB_LIMIT) begin
              // Budget exhausted with the value still too large.
              err       <= 1'b1;
              res_data  <= ext[N-1:0];
              res_valid <= 1'b1;
              state     <= OUT;
            end else begin
              ext     <= ext - m_ext;
              sub_cnt <= sub_cnt + 1'b1;
            end
          end else begin
            res_data  <= ext[N-1:0];
            res_valid <= 1'b1;
            state     <= OUT;
          end
        end

        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CRES_CYCLE_CNT_EN
  // Job duration counter: restarts with each accepted job and stops once a
  // result is presented, so the consumer can read it during the OUT stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      cyc_cnt <= '0;
    end else if (busy && !res_valid && (cyc_cnt != 16'hFFFF)) begin
      cyc_cnt <= cyc_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ntt_carry_resolve.sv
// tb_ntt_carry_resolve
//   Self-checking bench for ntt_carry_resolve with N=16, W=4, CW=8. Two
//   instances share every input: dut_a uses MAX_SUB=32 and dut_b uses
//   MAX_SUB=4, so each job exercises both the normal and the budget-limited
//   reduction. Expected residues come from a plain-integer model (division
//   and remainder), and each directed job also carries literal expectations.
//   Honours CRES_CYCLE_CNT_EN when the design is built with it.

module tb_ntt_carry_resolve;

  localparam int N  = 16;
  localparam int W  = 4;
  localparam int CW = 8;
  localparam int K  = N / W;

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  m_in;
  logic          coef_valid;
  logic [CW-1:0] coef_data;
  logic          res_ready;

  logic          coef_ready_a, res_valid_a, err_a, busy_a;
  logic [N-1:0]  res_data_a;
  logic          coef_ready_b, res_valid_b, err_b, busy_b;
  logic [N-1:0]  res_data_b;
`ifdef CRES_CYCLE_CNT_EN
  logic [15:0]   cyc_cnt_a, cyc_cnt_b;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic          job_live = 1'b0;
  logic [N-1:0]  exp_res_a, exp_res_b;
  logic          exp_err_a, exp_err_b;
  int            exp_lat_a, exp_lat_b;

  ntt_carry_resolve #(.N(N), .W(W), .CW(CW), .MAX_SUB(32)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .m_in       (m_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready_a),
    .coef_data  (coef_data),
    .res_valid  (res_valid_a),
    .res_ready  (res_ready),
    .res_data   (res_data_a),
    .err        (err_a),
    .busy       (busy_a)
`ifdef CRES_CYCLE_CNT_EN
    ,
    .cyc_cnt    (cyc_cnt_a)
`endif
  );

  ntt_carry_resolve #(.N(N), .W(W), .CW(CW), .MAX_SUB(4)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .m_in       (m_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready_b),
    .coef_data  (coef_data),
    .res_valid  (res_valid_b),
    .res_ready  (res_ready),
    .res_data   (res_data_b),
    .err        (err_b),
    .busy       (busy_b)
`ifdef CRES_CYCLE_CNT_EN
    ,
    .cyc_cnt    (cyc_cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Integer model: the value is the weighted sum of the coefficients; the
  // residue is value mod m when the quotient fits the budget, otherwise the
  // value after max_sub subtractions. lat counts edges from the last
  // coefficient handshake to res_valid (flush, then one per reduce cycle).
  function automatic void model(input logic [N-1:0] m, input logic [31:0] coefs,
                                input int max_sub, output logic [N-1:0] res,
                                output logic e, output int lat);
    longint v, q, mm;
    v  = 0;
    mm = longint'(m);
    for (int i = 0; i < K; i++) v = v + (longint'(coefs[8*i +: 8]) << (W * i));
    if (mm == 0) begin
      e   = 1'b1;
      lat = 1;
    end else begin
      q = v / mm;
      if (q <= longint'(max_sub)) begin
        v   = v % mm;
        e   = 1'b0;
        lat = int'(q) + 2;
      end else begin
        v   = v - longint'(max_sub) * mm;
        e   = 1'b1;
        lat = max_sub + 2;
      end
    end
    res = v[N-1:0];
  endfunction

  // Every cycle: with no job in flight nothing may be valid; while a result
  // is presented it must match the model and stay put through any stall.
  always @(negedge clk) begin
    if (!rst) begin
      if (!job_live) begin
        checkOutput("idle_valid_a", 32'(res_valid_a), 32'd0);
        checkOutput("idle_valid_b", 32'(res_valid_b), 32'd0);
      end else begin
        if (res_valid_a) begin
          checkOutput("res_a", 32'(res_data_a), 32'(exp_res_a));
          checkOutput("err_a", 32'(err_a), 32'(exp_err_a));
          checkOutput("out_ready_a", 32'(coef_ready_a), 32'd0);
          checkOutput("out_busy_a", 32'(busy_a), 32'd1);
        end
        if (res_valid_b) begin
          checkOutput("res_b", 32'(res_data_b), 32'(exp_res_b));
          checkOutput("err_b", 32'(err_b), 32'(exp_err_b));
          checkOutput("out_ready_b", 32'(coef_ready_b), 32'd0);
        end
      end
    end
  end

  // Start a job at edge t0, feed the coefficients, wait for both results,
  // optionally stall the consumer, then complete the result handshake.
  task automatic applyStimulus(input string tag, input logic [N-1:0] m,
                               input logic [31:0] coefs, input bit gaps,
                               input int hold, input bit poke,
                               input logic [N-1:0] lit_a, input logic lit_ea,
                               input logic [N-1:0] lit_b, input logic lit_eb);
    int t0, t_hs, ta, tb, guard;
    model(m, coefs, 32, exp_res_a, exp_err_a, exp_lat_a);
    model(m, coefs, 4,  exp_res_b, exp_err_b, exp_lat_b);
    $display("[TB] job %s", tag);
    job_live = 1'b1;
    start    = 1'b1;
    m_in     = m;
    @(posedge clk); #1;
    start = 1'b0;
    t0    = cyc;
    checkOutput({tag, "_busy"}, 32'(busy_a), 32'd1);

    for (int i = 0; i < K; i++) begin
      if (gaps) begin
        coef_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          coef_data = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      coef_valid = 1'b1;
      coef_data  = coefs[8*i +: 8];
      guard      = 0;
      while (!coef_ready_a && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 20) failNow({tag, "_coef_ready"});
      @(posedge clk); #1;
    end
    coef_valid = 1'b0;
    coef_data  = 8'($urandom);
    t_hs       = cyc;

    ta = -1;
    tb = -1;
    guard = 0;
    while ((ta < 0 || tb < 0) && guard < 200) begin
      if (ta < 0 && res_valid_a) ta = cyc;
      if (tb < 0 && res_valid_b) tb = cyc;
      if (ta < 0 || tb < 0) begin
        @(posedge clk); #1;
        guard++;
      end
    end
    if (ta < 0 || tb < 0) begin
      failNow({tag, "_res_valid"});
    end else begin
      checkOutput({tag, "_lat_a"}, 32'(ta - t_hs), 32'(exp_lat_a));
      checkOutput({tag, "_lat_b"}, 32'(tb - t_hs), 32'(exp_lat_b));
      // Without gaps the K handshakes occupy the first K edges after t0.
      if (!gaps) checkOutput({tag, "_start_lat_a"}, 32'(ta - t0), 32'(K + exp_lat_a));
      checkOutput({tag, "_lit_res_a"}, 32'(res_data_a), 32'(lit_a));
      checkOutput({tag, "_lit_err_a"}, 32'(err_a), 32'(lit_ea));
      checkOutput({tag, "_lit_res_b"}, 32'(res_data_b), 32'(lit_b));
      checkOutput({tag, "_lit_err_b"}, 32'(err_b), 32'(lit_eb));
`ifdef CRES_CYCLE_CNT_EN
      checkOutput({tag, "_cyc_cnt_a"}, 32'(cyc_cnt_a), 32'(ta - t0));
`endif
    end

    for (int h = 0; h < hold; h++) begin
      if (poke && h == 2) begin
        start = 1'b1;
        m_in  = 16'h0000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      checkOutput({tag, "_stall_valid_a"}, 32'(res_valid_a), 32'd1);
    end
    start = 1'b0;
    m_in  = m;

    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    job_live  = 1'b0;
    checkOutput({tag, "_done_valid_a"}, 32'(res_valid_a), 32'd0);
    checkOutput({tag, "_done_valid_b"}, 32'(res_valid_b), 32'd0);
    checkOutput({tag, "_done_err_a"}, 32'(err_a), 32'd0);
    checkOutput({tag, "_done_busy_a"}, 32'(busy_a), 32'd0);
    checkOutput({tag, "_done_busy_b"}, 32'(busy_b), 32'd0);
    if (poke) begin
      // The start pulsed during the stall must not have launched a job.
      repeat (2) @(posedge clk);
      #1;
      checkOutput({tag, "_poke_busy"}, 32'(busy_a), 32'd0);
      checkOutput({tag, "_poke_ready"}, 32'(coef_ready_a), 32'd0);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy_a"}, 32'(busy_a), 32'd0);
    checkOutput({tag, "_ready_a"}, 32'(coef_ready_a), 32'd0);
    checkOutput({tag, "_valid_a"}, 32'(res_valid_a), 32'd0);
    checkOutput({tag, "_err_a"}, 32'(err_a), 32'd0);
    checkOutput({tag, "_data_a"}, 32'(res_data_a), 32'd0);
    checkOutput({tag, "_busy_b"}, 32'(busy_b), 32'd0);
`ifdef CRES_CYCLE_CNT_EN
    checkOutput({tag, "_cyc_cnt_a"}, 32'(cyc_cnt_a), 32'd0);
`endif
  endtask

  // Start a job, deliver two coefficients, then reset mid-cycle.
  task automatic resetMidJob();
    $display("[TB] job reset_mid");
    start = 1'b1;
    m_in  = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      coef_valid = 1'b1;
      coef_data  = 8'h5A;
      @(posedge clk); #1;
    end
    coef_valid = 1'b0;
    checkOutput("mid_busy", 32'(busy_a), 32'd1);
    #2 rst = 1'b1;
    #1 checkResetState("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkResetState("post_rst");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    m_in       = '0;
    coef_valid = 1'b0;
    coef_data  = '0;
    res_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    checkResetState("idle");

    // 0x1F < M: no subtraction. Start sampled at edge t0, res_valid six
    // edges later (the seventh cycle counting the start cycle).
    applyStimulus("small", 16'hFFFF, 32'h0000001F, 1'b0, 0, 1'b0,
                  16'h001F, 1'b0, 16'h001F, 1'b0);
    // 0xFF x4 = 0x10FFEF = 17 * 0xFFFF. dut_b stops after 4 subtractions:
    // 0x10FFEF - 4*0xFFFF = 0xCFFF3.
    applyStimulus("full", 16'hFFFF, 32'hFFFFFFFF, 1'b0, 0, 1'b0,
                  16'h0000, 1'b0, 16'hFFF3, 1'b1);
    // Zero modulus: value 0x56855, low limbs 0x6855 reported with err.
    applyStimulus("m_zero", 16'h0000, 32'h4CA71235, 1'b0, 0, 1'b0,
                  16'h6855, 1'b1, 16'h6855, 1'b1);
    // 0x4960C = 9*0x8001 + 0x1603; dut_b: 0x4960C - 4*0x8001 = 0x29608.
    applyStimulus("mid", 16'h8001, 32'h3BE1479C, 1'b0, 2, 1'b0,
                  16'h1603, 1'b0, 16'h9608, 1'b1);
    // Same as "full" with random gaps, a 5-cycle consumer stall and a stray
    // start during the stall.
    applyStimulus("gappy", 16'hFFFF, 32'hFFFFFFFF, 1'b1, 5, 1'b1,
                  16'h0000, 1'b0, 16'hFFF3, 1'b1);

    resetMidJob();
    applyStimulus("after_rst", 16'hFFFF, 32'h0000001F, 1'b0, 0, 1'b0,
                  16'h001F, 1'b0, 16'h001F, 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
